sram_1p_mbist: RTL and testbench
================================

# sram_1p_mbist

Parametrised behavioural single-port SRAM model with an integrated March C- memory BIST engine. It replaces the external-mux BIST scheme: the functional port and the on-chip BIST controller share one clock and one array, and the output path has configurable read latency. It sits under each SRAM macro wrapper in simulation and is the golden model for array-level BIST bring-up.

## Interface
Parameters:
- P_DATA_WIDTH, 64, word width in bits.
- P_ADDR_WIDTH, 6, address width; depth = 2**P_ADDR_WIDTH.
- P_READ_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports (one clock; reset is synchronous and active-high):
- A_CLK  in  1  clock; all state updates on rising edge.
- A_RST  in  1  synchronous active-high reset.
- A_ADDR  in  P_ADDR_WIDTH  functional address.
- A_DIN  in  P_DATA_WIDTH  functional write data.
- A_BM  in  P_DATA_WIDTH  bit write mask; bit i written when A_BM[i]=1.
- A_MEN  in  1  memory enable.
- A_WEN  in  1  write enable.
- A_REN  in  1  read enable; with A_WEN=1 gives write-through.
- A_DLY  in  1  delay select; ignored in model.
- A_DOUT  out  P_DATA_WIDTH  read data.
- A_BIST_START  in  1  single-cycle pulse starting a March run.
- A_BIST_BUSY  out  1  high while March runs.
- A_BIST_DONE  out  1  sticky run-complete flag.
- A_BIST_FAIL  out  1  sticky miscompare flag; valid when A_BIST_DONE=1.

## Operation
- Functional access (BUSY=0): MEN&WEN writes (mem & ~BM) | (DIN & BM); if also REN, read stage loads the merged word. MEN&REN&~WEN loads mem[ADDR]. Otherwise read stage holds.
- BUSY=1: functional inputs fully ignored (no writes, read stage driven only by BIST reads).
- A_BIST_START with BUSY=0: clear DONE and FAIL, enter M0. START while BUSY=1 ignored.
- March elements, all-zero/all-one backgrounds, BM forced all-ones: M0 ⇑ w0; M1 ⇑ (r0,w1); M2 ⇑ (r1,w0); M3 ⇓ (r0,w1); M4 ⇓ (r1,w0); M5 ⇑ r0. One operation per cycle; in M1–M4 read then write same address on consecutive cycles. Total 10·2**P_ADDR_WIDTH operations.
- FSM: IDLE -> M0 -> M1 -> M2 -> M3 -> M4 -> M5 -> DRAIN -> IDLE. Element advances after op on last address (max for ⇑, 0 for ⇓); address counter wraps to start address of the next element.
- Compare: expected word and valid tag pipelined P_READ_LAT cycles alongside the read; any mismatch with A_DOUT sets FAIL.
- DRAIN waits P_READ_LAT cycles for outstanding compares, then DONE=1, BUSY=0.
- A_DOUT reflects BIST reads during a run; after run it holds the last read word (all-zeros) until the next read.

## Timing
- Reset values: A_DOUT=0, all read pipeline stages 0, BUSY=0, DONE=0, FAIL=0, FSM IDLE, address counter 0. Array contents not reset.
- Read latency: read sampled at edge t -> A_DOUT valid after edge t+P_READ_LAT-1 (1: directly from read register; 2: one extra register, loaded every cycle).
- START sampled at edge t0: BUSY=1 after t0; first op at edge t0+1; last op at edge t0+10N (N=depth); DONE=1 and BUSY=0 after edge t0+10N+P_READ_LAT+1.
- Reset mid-run: returns to IDLE, flags cleared, array contents undefined; no resumption.
- START coincident with functional access: access ignored, run starts.

## Configuration
- SRAM_BIST_DIAG_EN defined: adds outputs A_BIST_FAIL_ADDR (P_ADDR_WIDTH, address of first miscompare, reset 0) and A_BIST_FAIL_CNT (16 bits, saturating at 16'hFFFF, reset 0); both cleared on START.
- Undefined: ports and capture logic absent; only pass/fail reported.

## Structure
- Package sram_mbist_pkg: March state enum, element direction/expected/write-value constants, fail-count width localparam (16), op-count function 10·2**aw.
- Sub-module sram_mbist_ctrl: FSM, address counter, expected-data/valid pipeline and compare; top holds array, port mux and read pipeline.

## Test plan
- AW=4, DW=8, LAT=1: write 0xA5 to addr 3 BM=0xFF, read addr 3 -> A_DOUT=0xA5 next cycle; write 0x0F BM=0x0F with REN -> A_DOUT=0xA5 & 0xF0 | 0x0F = 0xAF.
- Same config, START at t0 -> BUSY for 160 ops, DONE after edge t0+162, FAIL=0, diag count 0.
- LAT=2 repeat -> DONE after edge t0+163, FAIL=0; functional read shows data two edges after sampling.
- Deposit bit 3 of word 5 to 1 after its M0 write, before M1 read -> FAIL=1; with SRAM_BIST_DIAG_EN FAIL_ADDR=5, FAIL_CNT=1.
- Functional write to addr 2 and second START while BUSY -> array word 2 unchanged by functional port, run not restarted, DONE timing unchanged.
- Assert A_RST at t0+50 -> BUSY=DONE=FAIL=0, A_DOUT=0 next cycle; new START completes normally.

Source files
------------

// File: rtl/sram_mbist_pkg.sv
// sram_mbist_pkg: March C- states, per-element direction/data tables and shared sizing helpers.
package sram_mbist_pkg;
  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN} march_state_t;
  // One bit per state ordinal: M3/M4 descend, M1..M5 read, M0..M4 write.
  localparam logic [7:0] ELEM_DOWN = 8'b0011_0000;
  localparam logic [7:0] ELEM_RD   = 8'b0111_1100;
  localparam logic [7:0] ELEM_WR   = 8'b0011_1110;
  localparam logic [7:0] EXP_ONE   = 8'b0010_1000;
  localparam logic [7:0] WR_ONE    = 8'b0001_0100;
  localparam int FAIL_CNT_W = 16;
  function automatic int op_count(input int aw);
    return 10 * (2 ** aw);
  endfunction
endpackage

// File: rtl/sram_mbist_ctrl.sv
// sram_mbist_ctrl: March C- sequencer, expected-data pipeline and compare; SRAM_BIST_DIAG_EN adds fail address/count capture.
module sram_mbist_ctrl
  import sram_mbist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 64,
  parameter int P_ADDR_WIDTH = 6,
  parameter int P_READ_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [P_DATA_WIDTH-1:0] dout,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic                    op_en,
  output logic                    op_we,
  output logic                    op_rd,
  output logic [P_ADDR_WIDTH-1:0] op_addr,
  output logic [P_DATA_WIDTH-1:0] op_wdata
`ifdef SRAM_BIST_DIAG_EN
  ,
  output logic [P_ADDR_WIDTH-1:0] fail_addr,
  output logic [FAIL_CNT_W-1:0]   fail_cnt
`endif
);
  march_state_t state, state_n, nxt;
  logic [P_ADDR_WIDTH-1:0] addr, addr_n;
  logic ph, ph_n, go, two_op, adv, last, drained, miss;
  logic [1:0] dcnt, dcnt_n;
  logic [P_READ_LAT-1:0] v_q;
  logic [P_DATA_WIDTH-1:0] exp_q [P_READ_LAT];
  assign busy = state != S_IDLE;
  assign go = start & ~busy;
  assign drained = state == S_DRAIN && dcnt == 2'(P_READ_LAT);
  assign miss = v_q[P_READ_LAT-1] && dout != exp_q[P_READ_LAT-1];
  assign op_addr = addr;
  assign op_wdata = {P_DATA_WIDTH{WR_ONE[state]}};
  always_comb begin
    nxt = march_state_t'(state + 3'd1);
    two_op = ELEM_RD[state] & ELEM_WR[state];
    op_en = busy && state != S_DRAIN;
    op_we = op_en & ELEM_WR[state] & (~two_op | ph);
    op_rd = op_en & ELEM_RD[state] & ~op_we;
    adv = op_en & (~two_op | ph);
    last = ELEM_DOWN[state] ? addr == '0 : addr == '1;
    state_n = go ? S_M0 : drained ? S_IDLE : (adv & last) ? nxt : state;
    addr_n = (adv & last) ? {P_ADDR_WIDTH{ELEM_DOWN[nxt]}}
           : adv ? (ELEM_DOWN[state] ? addr - P_ADDR_WIDTH'(1) : addr + P_ADDR_WIDTH'(1)) : addr;
    ph_n = op_en & two_op & ~ph;
    dcnt_n = (state == S_DRAIN && !drained) ? dcnt + 2'd1 : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      addr <= '0;
      ph <= 1'b0;
      dcnt <= 2'd0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      ph <= ph_n;
      dcnt <= dcnt_n;
    end
  end
  // Expected word and valid tag travel with the read so the compare lines up with A_DOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < P_READ_LAT; i++) exp_q[i] <= '0;
      done <= 1'b0;
      fail <= 1'b0;
    end else begin
      v_q[0] <= op_rd;
      exp_q[0] <= {P_DATA_WIDTH{EXP_ONE[state]}};
      for (int i = 1; i < P_READ_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
      done <= go ? 1'b0 : drained ? 1'b1 : done;
      fail <= go ? 1'b0 : miss ? 1'b1 : fail;
    end
  end
`ifdef SRAM_BIST_DIAG_EN
  logic [P_ADDR_WIDTH-1:0] a_q [P_READ_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P_READ_LAT; i++) a_q[i] <= '0;
      fail_addr <= '0;
      fail_cnt <= '0;
    end else begin
      a_q[0] <= addr;
      for (int i = 1; i < P_READ_LAT; i++) a_q[i] <= a_q[i-1];
      fail_addr <= go ? '0 : (miss & ~fail) ? a_q[P_READ_LAT-1] : fail_addr;
      fail_cnt <= go ? '0 : (miss && fail_cnt != '1) ? fail_cnt + FAIL_CNT_W'(1) : fail_cnt;
    end
  end
`endif
endmodule

// File: rtl/sram_1p_mbist.sv
// sram_1p_mbist: single-port SRAM model with built-in March C- BIST; SRAM_BIST_DIAG_EN adds fail address/count outputs.
module sram_1p_mbist
  import sram_mbist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 64,
  parameter int P_ADDR_WIDTH = 6,
  parameter int P_READ_LAT   = 1
) (
  input  logic                    A_CLK,
  input  logic                    A_RST,
  input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
  input  logic [P_DATA_WIDTH-1:0] A_DIN,
  input  logic [P_DATA_WIDTH-1:0] A_BM,
  input  logic                    A_MEN,
  input  logic                    A_WEN,
  input  logic                    A_REN,
  input  logic                    A_DLY,
  output logic [P_DATA_WIDTH-1:0] A_DOUT,
  input  logic                    A_BIST_START,
  output logic                    A_BIST_BUSY,
  output logic                    A_BIST_DONE,
  output logic                    A_BIST_FAIL
`ifdef SRAM_BIST_DIAG_EN
  ,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR,
  output logic [FAIL_CNT_W-1:0]   A_BIST_FAIL_CNT
`endif
);
  logic [P_DATA_WIDTH-1:0] mem [2**P_ADDR_WIDTH];
  logic busy, op_en, op_we, op_rd, en, we, re, unused;
  logic [P_ADDR_WIDTH-1:0] op_addr, addr;
  logic [P_DATA_WIDTH-1:0] op_wdata, din, bm, merged, rd_q;
  sram_mbist_ctrl #(
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .P_ADDR_WIDTH(P_ADDR_WIDTH),
    .P_READ_LAT(P_READ_LAT)
  ) u_ctrl (
    .clk(A_CLK),
    .rst(A_RST),
    .start(A_BIST_START),
    .dout(A_DOUT),
    .busy(busy),
    .done(A_BIST_DONE),
    .fail(A_BIST_FAIL),
    .op_en(op_en),
    .op_we(op_we),
    .op_rd(op_rd),
    .op_addr(op_addr),
    .op_wdata(op_wdata)
`ifdef SRAM_BIST_DIAG_EN
    ,
    .fail_addr(A_BIST_FAIL_ADDR),
    .fail_cnt(A_BIST_FAIL_CNT)
`endif
  );
  assign A_BIST_BUSY = busy;
  assign unused = A_DLY;
  // A starting run wins over a coincident functional access.
  assign en = busy ? op_en : A_MEN & ~A_BIST_START;
  assign we = busy ? op_we : A_WEN;
  assign re = busy ? op_rd : A_REN;
  assign addr = busy ? op_addr : A_ADDR;
  assign din = busy ? op_wdata : A_DIN;
  assign bm = busy ? '1 : A_BM;
  assign merged = (mem[addr] & ~bm) | (din & bm);
  always_ff @(posedge A_CLK) if (en && we) mem[addr] <= merged;
  always_ff @(posedge A_CLK) begin
    if (A_RST) rd_q <= '0;
    else if (en && re) rd_q <= we ? merged : mem[addr];
  end
  generate
    if (P_READ_LAT == 2) begin : g_lat2
      logic [P_DATA_WIDTH-1:0] rd2_q;
      always_ff @(posedge A_CLK) rd2_q <= A_RST ? '0 : rd_q;
      assign A_DOUT = rd2_q;
    end else begin : g_lat1
      assign A_DOUT = rd_q;
    end
  endgenerate
endmodule

// File: tb/tb_sram_1p_mbist.sv
// tb_sram_1p_mbist: checks latency-1 and latency-2 instances driven in lockstep against tables and a word-level model.
module tb_sram_1p_mbist;
  localparam int AW = 4, DW = 8, N = 16;
  logic clk = 1'b0, rst, men, wen, ren, dly, start;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, bm, dout1, dout2;
  logic busy1, done1, fail1, busy2, done2, fail2;
`ifdef SRAM_BIST_DIAG_EN
  logic [AW-1:0] fa1, fa2;
  logic [15:0] fc1, fc2;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] rmem [N];
  logic [DW-1:0] r1, r2;
  typedef struct {logic m, w, r; logic [AW-1:0] a; logic [DW-1:0] d, b, e;} vec_t;
  vec_t tbl [7];
  always #5 clk = ~clk;
  sram_1p_mbist #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_READ_LAT(1)) dut1 (
    .A_CLK(clk), .A_RST(rst), .A_ADDR(addr), .A_DIN(din), .A_BM(bm), .A_MEN(men),
    .A_WEN(wen), .A_REN(ren), .A_DLY(dly), .A_DOUT(dout1), .A_BIST_START(start),
    .A_BIST_BUSY(busy1), .A_BIST_DONE(done1), .A_BIST_FAIL(fail1)
`ifdef SRAM_BIST_DIAG_EN
    , .A_BIST_FAIL_ADDR(fa1), .A_BIST_FAIL_CNT(fc1)
`endif
  );
  sram_1p_mbist #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_READ_LAT(2)) dut2 (
    .A_CLK(clk), .A_RST(rst), .A_ADDR(addr), .A_DIN(din), .A_BM(bm), .A_MEN(men),
    .A_WEN(wen), .A_REN(ren), .A_DLY(dly), .A_DOUT(dout2), .A_BIST_START(start),
    .A_BIST_BUSY(busy2), .A_BIST_DONE(done2), .A_BIST_FAIL(fail2)
`ifdef SRAM_BIST_DIAG_EN
    , .A_BIST_FAIL_ADDR(fa2), .A_BIST_FAIL_CNT(fc2)
`endif
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // One functional cycle; the model keeps the array and the read-data history.
  task automatic step(input logic m, input logic w, input logic r, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] b);
    logic [DW-1:0] mg;
    men = m; wen = w; ren = r; addr = a; din = d; bm = b; start = 1'b0;
    @(posedge clk);
    mg = (rmem[a] & ~b) | (d & b);
    r2 = r1;
    if (m && w) begin
      rmem[a] = mg;
      if (r) r1 = mg;
    end else if (m && r) r1 = rmem[a];
    #1;
  endtask
  task automatic check_idle_flags(input string nm);
    chk({nm, "_busy1"}, busy1, 0); chk({nm, "_busy2"}, busy2, 0);
    chk({nm, "_done1"}, done1, 0); chk({nm, "_done2"}, done2, 0);
    chk({nm, "_fail1"}, fail1, 0); chk({nm, "_fail2"}, fail2, 0);
    chk({nm, "_dout1"}, dout1, 0); chk({nm, "_dout2"}, dout2, 0);
  endtask
  // mode 0 clean, 1 functional write + second START mid-run, 2 injected fault, 3 reset mid-run
  task automatic run_bist(input int mode);
    int k1, k2;
    k1 = 0; k2 = 0;
    men = 0; wen = 0; ren = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (mode == 1 && k == 20) begin
        men = 1; wen = 1; ren = 1; addr = 2; din = '1; bm = '1; start = 1'b1;
      end
      if (mode == 3 && k == 50) rst = 1'b1;
      @(posedge clk); #1;
      men = 0; wen = 0; ren = 0; start = 1'b0;
      if (mode == 2 && k == 10) begin
        dut1.mem[5][3] = 1'b1;
        dut2.mem[5][3] = 1'b1;
      end
      if (rst) begin
        check_idle_flags("midrst");
        rst = 1'b0;
        r1 = '0; r2 = '0;
        return;
      end
      if (k == 1) begin
        chk("busy1_start", busy1, 1); chk("busy2_start", busy2, 1);
        chk("fail1_cleared", fail1, 0); chk("done1_cleared", done1, 0);
      end
      if (k == 10 * N) begin
        chk("busy1_lastop", busy1, 1); chk("busy2_lastop", busy2, 1);
      end
      if (done1 && k1 == 0) k1 = k;
      if (done2 && k2 == 0) k2 = k;
      if (k1 != 0 && k2 != 0) break;
    end
    chk("done1_edge", k1, 10 * N + 2);
    chk("done2_edge", k2, 10 * N + 3);
    chk("end_busy1", busy1, 0); chk("end_busy2", busy2, 0);
    chk("end_fail1", fail1, mode == 2); chk("end_fail2", fail2, mode == 2);
    chk("end_dout1", dout1, 0); chk("end_dout2", dout2, 0);
`ifdef SRAM_BIST_DIAG_EN
    chk("fail_addr1", fa1, mode == 2 ? 5 : 0); chk("fail_addr2", fa2, mode == 2 ? 5 : 0);
    chk("fail_cnt1", fc1, mode == 2); chk("fail_cnt2", fc2, mode == 2);
`endif
    for (int i = 0; i < N; i++) rmem[i] = '0;
    r1 = '0; r2 = '0;
  endtask
  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      dly = 1'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, N - 1)), DW'($urandom), DW'($urandom));
      chk("rnd_dout1", dout1, r1);
      chk("rnd_dout2", dout2, r2);
      chk("rnd_busy1", busy1, 0);
    end
  endtask
  initial begin
    tbl[0] = '{1, 1, 0, 3, 8'hA5, 8'hFF, 8'h00};
    tbl[1] = '{1, 0, 1, 3, 8'h00, 8'h00, 8'hA5};
    tbl[2] = '{1, 1, 1, 3, 8'h0F, 8'h0F, 8'hAF};
    tbl[3] = '{0, 0, 1, 3, 8'h00, 8'h00, 8'hAF};
    tbl[4] = '{1, 1, 0, 9, 8'h3C, 8'hFF, 8'hAF};
    tbl[5] = '{1, 0, 1, 9, 8'h00, 8'h00, 8'h3C};
    tbl[6] = '{1, 1, 1, 9, 8'hF0, 8'h00, 8'h3C};
    rst = 1'b1; men = 0; wen = 0; ren = 0; dly = 0; start = 0; addr = '0; din = '0; bm = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_flags("reset");
`ifdef SRAM_BIST_DIAG_EN
    chk("reset_fa1", fa1, 0); chk("reset_fc1", fc1, 0);
`endif
    rst = 1'b0;
    r1 = '0; r2 = '0;
    for (int i = 0; i < N; i++) rmem[i] = 'x;
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].m, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].b);
      chk("tbl_dout1", dout1, tbl[i].e);
      chk("tbl_dout2", dout2, i == 0 ? 8'h00 : tbl[i-1].e);
    end
    for (int i = 0; i < N; i++) step(1, 1, 0, AW'(i), DW'($urandom), '1);
    random_phase(150);
    run_bist(0);
    random_phase(60);
    run_bist(1);
    run_bist(2);
    run_bist(3);
    run_bist(0);
    random_phase(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
